// File: rtl/alu_defs_pkg.sv
// alu_defs_pkg: ALU operation codes and FSM state encoding shared by the ALU
// control decoder and the multicycle ALU.
//   ALU_OP_*     : 4-bit operation codes
//   alu_state_t  : multicycle ALU FSM states
//   is_shift_op  : true for the serially executed shift codes
package alu_defs_pkg;

    localparam logic [3:0] ALU_OP_AND     = 4'b0000;
    localparam logic [3:0] ALU_OP_OR      = 4'b0001;
    localparam logic [3:0] ALU_OP_NOR     = 4'b0010;
    localparam logic [3:0] ALU_OP_ADD     = 4'b0011;
    localparam logic [3:0] ALU_OP_SUB     = 4'b0100;
    localparam logic [3:0] ALU_OP_SLL     = 4'b0110;
    localparam logic [3:0] ALU_OP_SRL     = 4'b0111;
    localparam logic [3:0] ALU_OP_ILLEGAL = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle shifter with accumulator, down-counter
// and direction bit.
//   clk, reset : clock, asynchronous active-low reset
//   load       : capture data/amount/left into accumulator, counter, direction
//   enable     : shift accumulator by one bit and decrement counter
//   left       : direction at load (1 = left, 0 = right, zero fill)
//   data       : value to shift
//   amount     : number of single-bit shifts
//   shifted    : accumulator shifted by one bit (value after the next enable)
//   last       : the next enable performs the final shift
module alu_serial_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               enable,
    input  logic               left,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] amount,
    output logic [WIDTH-1:0]   shifted,
    output logic               last
);
    import alu_defs_pkg::*;

    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] count;
    logic               dir;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            count <= '0;
            dir   <= 1'b0;
        end else if (load) begin
            acc   <= data;
            count <= amount;
            dir   <= left;
        end else if (enable) begin
            acc   <= shifted;
            count <= count - SHAMT_W'(1);
        end
    end

    assign shifted = dir ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
    assign last    = (count == SHAMT_W'(1));

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: execute-stage ALU with start/done handshake; logic and
// add/sub finish in one cycle, shifts run serially one bit per cycle.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : request, accepted when busy = 0
//   ALUOperation : operation code, sampled at accept
//   A, B, shamt  : operands (B is the shift source), sampled at accept
//   busy         : shift in progress, start ignored
//   done         : one-cycle completion pulse
//   ALUResult    : registered result, held until the next done
//   Zero         : registered ALUResult == 0
//   illegal      : completed request carried an unsupported code
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               illegal
);
    import alu_defs_pkg::*;

    alu_state_t       state, next_state;
    logic [WIDTH-1:0] alu_val, res_next, shifted;
    logic             ill_op, ill_next, load_res, sh_load, sh_en, last;

    // Shift codes fall through to B here so that shamt = 0 completes at once.
    always_comb begin
        alu_val = '0;
        ill_op  = 1'b0;
        case (ALUOperation)
            ALU_OP_AND: alu_val = A & B;
            ALU_OP_OR:  alu_val = A | B;
            ALU_OP_NOR: alu_val = ~(A | B);
            ALU_OP_ADD: alu_val = A + B;
            ALU_OP_SUB: alu_val = A - B;
            ALU_OP_SLL,
            ALU_OP_SRL: alu_val = B;
            default:    ill_op  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // DONE accepts a new request exactly like IDLE, giving one result per cycle.
    always_comb begin
        next_state = state;
        load_res   = 1'b0;
        res_next   = alu_val;
        ill_next   = 1'b0;
        sh_load    = 1'b0;
        sh_en      = 1'b0;
        if (state == ST_SHIFT) begin
            sh_en = 1'b1;
            if (last) begin
                load_res   = 1'b1;
                res_next   = shifted;
                next_state = ST_DONE;
            end
        end else if (start) begin
            if (is_shift_op(ALUOperation) && shamt != '0) begin
                sh_load    = 1'b1;
                next_state = ST_SHIFT;
            end else begin
                load_res   = 1'b1;
                ill_next   = ill_op;
                next_state = ST_DONE;
            end
        end else begin
            next_state = ST_IDLE;
        end
    end

    alu_serial_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    (sh_load),
        .enable  (sh_en),
        .left    (ALUOperation == ALU_OP_SLL),
        .data    (B),
        .amount  (shamt),
        .shifted (shifted),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUResult <= '0;
            Zero      <= 1'b1;
            illegal   <= 1'b0;
        end else if (load_res) begin
            ALUResult <= res_next;
            Zero      <= (res_next == '0);
            illegal   <= ill_next;
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed self-checking bench for multicycle_alu.
module tb_multicycle_alu;
    import alu_defs_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A, B;
    logic [4:0]  shamt;
    logic        busy, done, Zero, illegal;
    logic [31:0] ALUResult;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_alu dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one request, wait for done, then check latency, busy cycles and outputs.
    // With poke set, a conflicting start is pulsed mid-operation and must be ignored.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_res,
                          input logic exp_ill, input int exp_lat, input bit poke);
        int lat, bcnt;
        @(negedge clk);
        ALUOperation = op; A = a; B = b; shamt = sh; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (poke && lat == 5) begin
                start = 1'b1; ALUOperation = ALU_OP_SRL; B = 32'h0; shamt = 5'd1;
            end else start = 1'b0;
        end while (!done && lat < 100);
        start = 1'b0;
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_busy"}, bcnt, exp_lat - 1);
        check({tag, "_res"},  ALUResult, exp_res);
        check({tag, "_zero"}, Zero, exp_res == 32'h0);
        check({tag, "_ill"},  illegal, exp_ill);
    endtask

    initial begin
        int seen;
        reset = 1'b0; start = 1'b0; ALUOperation = 4'h0; A = '0; B = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("rst_res",  ALUResult, 32'h0);
        check("rst_zero", Zero, 1'b1);
        check("rst_ill",  illegal, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b1;

        run_op("and", ALU_OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234, 1'b0, 1, 1'b0);
        run_op("nor", ALU_OP_NOR, 32'hF0F0_0000, 32'h0000_00FF, 5'd0, 32'h0F0F_FF00, 1'b0, 1, 1'b0);

        // Back-to-back SUB then ADD, second accepted in the done cycle of the first.
        @(negedge clk);
        ALUOperation = ALU_OP_SUB; A = 32'd5; B = 32'd5; shamt = 5'd0; start = 1'b1;
        @(posedge clk);
        #1 ALUOperation = ALU_OP_ADD; A = 32'hFFFF_FFFF; B = 32'd1;
        @(negedge clk);
        check("sub_done", done, 1'b1);
        check("sub_busy", busy, 1'b0);
        check("sub_res",  ALUResult, 32'h0);
        check("sub_zero", Zero, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("add_done", done, 1'b1);
        check("add_res",  ALUResult, 32'h0);
        check("add_zero", Zero, 1'b1);
        @(negedge clk);
        check("add_done_end", done, 1'b0);

        run_op("add7",   ALU_OP_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1, 1'b0);
        run_op("sll31",  ALU_OP_SLL, 32'h0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 32, 1'b1);
        run_op("srl4",   ALU_OP_SRL, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 5, 1'b0);
        run_op("srl0",   ALU_OP_SRL, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
        run_op("srl31",  ALU_OP_SRL, 32'h0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 32, 1'b0);
        run_op("sll3",   ALU_OP_SLL, 32'h0, 32'h0000_00F1, 5'd3, 32'h0000_0788, 1'b0, 4, 1'b0);
        run_op("ill9",   ALU_OP_ILLEGAL, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b1, 1, 1'b0);
        run_op("ill5",   4'b0101, 32'h1234, 32'h5678, 5'd3, 32'h0, 1'b1, 1, 1'b0);
        run_op("or",     ALU_OP_OR, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0, 1, 1'b0);

        // Reset in the third cycle of a 10-bit SLL aborts it.
        @(negedge clk);
        ALUOperation = ALU_OP_SLL; A = '0; B = 32'd1; shamt = 5'd10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_res",  ALUResult, 32'h0);
        check("mid_rst_zero", Zero, 1'b1);
        check("mid_rst_ill",  illegal, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("mid_rst_quiet", seen, 0);
        run_op("add5", ALU_OP_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
